cpu_regfile_scheduler: RTL
==========================

// Module: cpu_regfile_scheduler
// PURPOSE
//  Sequences and shares the tag-handshaked CPU register file between three requesters:
//  decode (2-operand read + rd reservation), writeback (write) and debug (1-register read/write).
//  Keeps a 32-entry pending-write scoreboard, stalls RAW/WAW hazards and drives the regfile tags.
//  Sits between the decode/writeback stages and the register file; debug shares the same ports.
// PARAMETERS
//  TAG_WIDTH        4  width of read/write tags; must equal the regfile tag width
//  DBG_STARVE_LIMIT 4  consecutive cycles debug may lose the read port before it is granted
// PORTS
//  i_clock          in   1   clock
//  i_reset          in   1   synchronous, active-high reset
//  i_dec_request    in   1   decode requests operand read (held until o_dec_ready)
//  i_dec_rs1_idx    in   5   operand 1 index
//  i_dec_rs2_idx    in   5   operand 2 index
//  i_dec_rd_idx     in   5   destination index to reserve
//  i_dec_rd_write   in   1   1 = reserve i_dec_rd_idx in scoreboard on accept
//  o_dec_ready      out  1   combinational accept strobe (1 cycle)
//  o_dec_valid      out  1   operand data valid (1-cycle pulse)
//  o_dec_rs1        out  32  operand 1 data
//  o_dec_rs2        out  32  operand 2 data
//  i_wb_request     in   1   writeback write (always accepted, 1-cycle strobe)
//  i_wb_rd_idx      in   5   writeback destination
//  i_wb_rd          in   32  writeback data
//  i_dbg_request    in   1   debug access request (held until o_dbg_done)
//  i_dbg_write      in   1   1 = write, 0 = read
//  i_dbg_idx        in   5   debug register index
//  i_dbg_wdata      in   32  debug write data
//  o_dbg_done       out  1   debug access complete (1-cycle pulse)
//  o_dbg_rdata      out  32  debug read data, valid with o_dbg_done on reads
//  o_busy_mask      out  32  scoreboard: bit n = write to xn pending
//  o_read_tag       out  TAG_WIDTH  regfile read tag
//  o_read_rs1_idx   out  5   regfile rs1 index
//  o_read_rs2_idx   out  5   regfile rs2 index
//  i_rs1            in   32  regfile rs1 data
//  i_rs2            in   32  regfile rs2 data
//  o_write_tag      out  TAG_WIDTH  regfile write tag
//  o_write_rd_idx   out  5   regfile write index
//  o_rd             out  32  regfile write data
// BEHAVIOUR
//  Reset: all outputs 0, both tags 0, scoreboard 0, debug FSM IDLE, in-flight responses dropped.
//  Tags: each issue increments the tag by 1 modulo 2^TAG_WIDTH (wrap legal); idx/data registered at the same edge.
//  Read issue: accept in cycle N -> tag/idx change at edge N+1 -> regfile latches at N+2 ->
//   o_dec_valid (or debug data capture) in cycle N+2. Latency 2; back-to-back issue every cycle.
//  A 2-stage valid/owner shift register routes i_rs1/i_rs2 to decode or debug.
//  Decode hazard: stall while busy[rs1] or busy[rs2] or (rd_write and busy[rd]); index 0 never busy.
//  Decode accept: reserve busy[rd] at edge N+1 if i_dec_rd_write and rd != 0.
//  Writeback: write issued every strobe with rd != 0; busy[rd] cleared at the same edge the write tag
//   changes; rd = 0 ignored (no tag change); write to non-busy register still issued.
//  Same-edge set and clear of one bit: set wins (unreachable while the WAW stall holds).
//  Read port arbitration: decode wins; debug wins after DBG_STARVE_LIMIT consecutive lost cycles.
//  Write port: writeback always wins; debug write waits for a cycle with no i_wb_request.
//  Debug FSM: IDLE -> RD_ISSUE (wait !busy[idx] and grant) -> RD_WAIT (2 cycles) -> DONE -> IDLE;
//   IDLE -> WR_ISSUE (wait !busy[idx], no wb) -> DONE -> IDLE. DONE pulses o_dbg_done.
//  Debug write to x0 completes with no regfile write; debug read of x0 returns 0.
//  Reset mid-access: FSM returns to IDLE, no o_dbg_done, pending reservations lost.
// TESTING
//  Reset, decode read rs1=2 rs2=0 -> o_dec_valid 2 cycles after accept, rs1=0x000103FC, rs2=0.
//  Decode reserve x5, next decode reads x5 -> stalled until wb x5=0xDEAD; then o_dec_rs1=0xDEAD.
//  Accept 20 back-to-back reads with TAG_WIDTH=4 -> tag wraps 15->0, every o_dec_valid correct.
//  Decode requests continuously, debug read x7 -> debug granted after 4 lost cycles, o_dbg_rdata=x7.
//  Writeback every cycle, debug write x3=0x55 -> completes only in first wb-free cycle; read back 0x55.
//  Assert i_reset during RD_WAIT -> no o_dbg_done, busy mask 0, tags 0 next cycle.

Source files
------------

// File: rtl/cpu_regfile_scheduler_if.sv
// Bundle between the scheduler and its clients: decode, writeback, debug and
// the tag-handshaked register file. Signal names keep the scheduler's view
// (i_ = into the scheduler, o_ = out of it).
//
// Handshakes:
//  - decode: i_dec_request is held with stable fields until o_dec_ready; the
//    cycle with request && ready is the accept. o_dec_valid pulses exactly two
//    cycles later with the operands.
//  - writeback: i_wb_request is a one-cycle strobe that is always accepted.
//  - debug: i_dbg_request is held with stable fields until o_dbg_done pulses;
//    o_dbg_rdata is meaningful in that cycle for reads.
//  - regfile: every change of o_read_tag / o_write_tag is one request; the
//    regfile acts on the edge after it sees the new tag.
interface cpu_regfile_scheduler_if #(
  parameter int TAG_WIDTH = 4
);
  logic                 i_dec_request;
  logic [4:0]           i_dec_rs1_idx;
  logic [4:0]           i_dec_rs2_idx;
  logic [4:0]           i_dec_rd_idx;
  logic                 i_dec_rd_write;
  logic                 o_dec_ready;
  logic                 o_dec_valid;
  logic [31:0]          o_dec_rs1;
  logic [31:0]          o_dec_rs2;
  logic                 i_wb_request;
  logic [4:0]           i_wb_rd_idx;
  logic [31:0]          i_wb_rd;
  logic                 i_dbg_request;
  logic                 i_dbg_write;
  logic [4:0]           i_dbg_idx;
  logic [31:0]          i_dbg_wdata;
  logic                 o_dbg_done;
  logic [31:0]          o_dbg_rdata;
  logic [31:0]          o_busy_mask;
  logic [TAG_WIDTH-1:0] o_read_tag;
  logic [4:0]           o_read_rs1_idx;
  logic [4:0]           o_read_rs2_idx;
  logic [31:0]          i_rs1;
  logic [31:0]          i_rs2;
  logic [TAG_WIDTH-1:0] o_write_tag;
  logic [4:0]           o_write_rd_idx;
  logic [31:0]          o_rd;

  // Scheduler side
  modport slave (
    input  i_dec_request, i_dec_rs1_idx, i_dec_rs2_idx, i_dec_rd_idx, i_dec_rd_write,
    output o_dec_ready, o_dec_valid, o_dec_rs1, o_dec_rs2,
    input  i_wb_request, i_wb_rd_idx, i_wb_rd,
    input  i_dbg_request, i_dbg_write, i_dbg_idx, i_dbg_wdata,
    output o_dbg_done, o_dbg_rdata, o_busy_mask,
    output o_read_tag, o_read_rs1_idx, o_read_rs2_idx,
    input  i_rs1, i_rs2,
    output o_write_tag, o_write_rd_idx, o_rd
  );

  // Client / regfile side
  modport master (
    output i_dec_request, i_dec_rs1_idx, i_dec_rs2_idx, i_dec_rd_idx, i_dec_rd_write,
    input  o_dec_ready, o_dec_valid, o_dec_rs1, o_dec_rs2,
    output i_wb_request, i_wb_rd_idx, i_wb_rd,
    output i_dbg_request, i_dbg_write, i_dbg_idx, i_dbg_wdata,
    input  o_dbg_done, o_dbg_rdata, o_busy_mask,
    input  o_read_tag, o_read_rs1_idx, o_read_rs2_idx,
    output i_rs1, i_rs2,
    input  o_write_tag, o_write_rd_idx, o_rd
  );
endinterface

// File: rtl/cpu_regfile_scheduler.sv
// Shares the tag-handshaked register file between decode, writeback and debug.
// Tracks pending writes in a 32-bit scoreboard, stalls RAW/WAW hazards on
// decode, arbitrates the read port (decode first, debug after a bounded number
// of losses) and the write port (writeback first), and routes read data back
// through a two-stage valid/owner pipe matching the regfile latency.
module cpu_regfile_scheduler #(
  parameter int TAG_WIDTH        = 4,  // must match the interface instance
  parameter int DBG_STARVE_LIMIT = 4
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  cpu_regfile_scheduler_if.slave  bus,
  output logic [2:0]              o_dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ISSUE = 3'd1,
    ST_RD_WAIT  = 3'd2,
    ST_WR_ISSUE = 3'd3,
    ST_DONE     = 3'd4
  } dbg_state_e;

  localparam int STARVE_W = (DBG_STARVE_LIMIT < 2) ? 1 : $clog2(DBG_STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0]  STARVE_MAX = STARVE_W'(DBG_STARVE_LIMIT);
  localparam logic [TAG_WIDTH-1:0] TAG_ONE    = TAG_WIDTH'(1);

  dbg_state_e           state_q;
  logic                 done_q;
  logic [31:0]          dbg_rdata_q;
  logic [STARVE_W-1:0]  starve_q;
  logic [31:0]          busy_q, busy_d, busy_set, busy_clr;
  logic [TAG_WIDTH-1:0] read_tag_q, write_tag_q;
  logic [4:0]           read_rs1_idx_q, read_rs2_idx_q, write_rd_idx_q;
  logic [31:0]          rd_q;
  logic [1:0]           pipe_valid_q, pipe_dbg_q;

  logic dec_hazard, dec_want, dec_accept;
  logic dbg_want, dbg_grant, rd_issue;
  logic wb_issue, dbg_wr_go, dbg_wr_issue;

  // Hazard detection, read/write port arbitration and scoreboard next state
  always_comb begin
    dec_hazard   = busy_q[bus.i_dec_rs1_idx] | busy_q[bus.i_dec_rs2_idx] |
                   (bus.i_dec_rd_write & busy_q[bus.i_dec_rd_idx]);
    dec_want     = bus.i_dec_request & ~dec_hazard;
    dbg_want     = (state_q == ST_RD_ISSUE) && !busy_q[bus.i_dbg_idx];
    // Debug only takes the port from a willing decode once it has lost enough times
    dbg_grant    = dbg_want && (!dec_want || (starve_q >= STARVE_MAX));
    dec_accept   = dec_want && !dbg_grant;
    rd_issue     = dec_accept || dbg_grant;
    wb_issue     = bus.i_wb_request && (bus.i_wb_rd_idx != 5'd0);
    // Any writeback strobe (even to x0) keeps the debug write off the port
    dbg_wr_go    = (state_q == ST_WR_ISSUE) && !busy_q[bus.i_dbg_idx] && !bus.i_wb_request;
    dbg_wr_issue = dbg_wr_go && (bus.i_dbg_idx != 5'd0);
    busy_set     = '0;
    busy_clr     = '0;
    if (dec_accept && bus.i_dec_rd_write && (bus.i_dec_rd_idx != 5'd0))
      busy_set = 32'd1 << bus.i_dec_rd_idx;
    if (wb_issue)
      busy_clr = 32'd1 << bus.i_wb_rd_idx;
    // Set wins over a same-edge clear of the same bit
    busy_d       = (busy_q & ~busy_clr) | busy_set;
  end

  // Read port: bump the tag and register the indices on every issue
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      read_tag_q     <= '0;
      read_rs1_idx_q <= '0;
      read_rs2_idx_q <= '0;
    end else if (rd_issue) begin
      read_tag_q     <= read_tag_q + TAG_ONE;
      read_rs1_idx_q <= dbg_grant ? bus.i_dbg_idx : bus.i_dec_rs1_idx;
      read_rs2_idx_q <= dbg_grant ? bus.i_dbg_idx : bus.i_dec_rs2_idx;
    end
  end

  // Write port: writeback first, debug write only in a writeback-free cycle
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      write_tag_q    <= '0;
      write_rd_idx_q <= '0;
      rd_q           <= '0;
    end else if (wb_issue) begin
      write_tag_q    <= write_tag_q + TAG_ONE;
      write_rd_idx_q <= bus.i_wb_rd_idx;
      rd_q           <= bus.i_wb_rd;
    end else if (dbg_wr_issue) begin
      write_tag_q    <= write_tag_q + TAG_ONE;
      write_rd_idx_q <= bus.i_dbg_idx;
      rd_q           <= bus.i_dbg_wdata;
    end
  end

  // Scoreboard and the valid/owner pipe that tracks reads through the regfile
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      busy_q       <= '0;
      pipe_valid_q <= '0;
      pipe_dbg_q   <= '0;
    end else begin
      busy_q       <= busy_d;
      pipe_valid_q <= {pipe_valid_q[0], rd_issue};
      pipe_dbg_q   <= {pipe_dbg_q[0], dbg_grant};
    end
  end

  // Count consecutive cycles a ready debug read lost the port to decode
  always_ff @(posedge i_clock) begin
    if (i_reset)
      starve_q <= '0;
    else if (dbg_want && !dbg_grant)
      starve_q <= starve_q + STARVE_W'(1);
    else
      starve_q <= '0;
  end

  // Debug access FSM with registered done pulse and read data
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      done_q      <= 1'b0;
      dbg_rdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE:
          if (bus.i_dbg_request)
            state_q <= bus.i_dbg_write ? ST_WR_ISSUE : ST_RD_ISSUE;
        ST_RD_ISSUE:
          if (dbg_grant)
            state_q <= ST_RD_WAIT;
        ST_RD_WAIT:
          if (pipe_valid_q[1] && pipe_dbg_q[1]) begin
            dbg_rdata_q <= (bus.i_dbg_idx == 5'd0) ? 32'd0 : bus.i_rs1;
            done_q      <= 1'b1;
            state_q     <= ST_DONE;
          end
        ST_WR_ISSUE:
          if (dbg_wr_go) begin
            dbg_rdata_q <= '0;
            done_q      <= 1'b1;
            state_q     <= ST_DONE;
          end
        ST_DONE:
          state_q <= ST_IDLE;
        default:
          state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_dec_ready    = dec_accept;
  assign bus.o_dec_valid    = pipe_valid_q[1] & ~pipe_dbg_q[1];
  assign bus.o_dec_rs1      = bus.o_dec_valid ? bus.i_rs1 : 32'd0;
  assign bus.o_dec_rs2      = bus.o_dec_valid ? bus.i_rs2 : 32'd0;
  assign bus.o_dbg_done     = done_q;
  assign bus.o_dbg_rdata    = done_q ? dbg_rdata_q : 32'd0;
  assign bus.o_busy_mask    = busy_q;
  assign bus.o_read_tag     = read_tag_q;
  assign bus.o_read_rs1_idx = read_rs1_idx_q;
  assign bus.o_read_rs2_idx = read_rs2_idx_q;
  assign bus.o_write_tag    = write_tag_q;
  assign bus.o_write_rd_idx = write_rd_idx_q;
  assign bus.o_rd           = rd_q;
  assign o_dbg_state        = state_q;

endmodule
